// File: rtl/ibex_irq_ctrl.sv
// ibex_irq_ctrl: interrupt sampling, NMI edge capture and fixed-priority request arbitration.
// Define IBEX_IRQ_SYNC_EN to add 2-flop synchronizers on irqs_i and irq_nm_i.
module ibex_irq_ctrl #(
  parameter bit NmiEnable = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [17:0] irqs_i,
  input  logic        irq_nm_i,
  input  logic [17:0] mie_i,
  input  logic        mstatus_mie_i,
  input  logic        debug_mode_i,
  input  logic        irq_ack_i,
  output logic [17:0] mip_o,
  output logic        irq_pending_o,
  output logic        irq_req_o,
  output logic [5:0]  irq_cause_o
);
  localparam logic [5:0] CauseNmi = 6'h3F;
  localparam logic [5:0] CauseExt = 6'h2B;
  localparam logic [5:0] CauseSw  = 6'h23;
  localparam logic [5:0] CauseTmr = 6'h27;
  typedef enum logic {IDLE, REQ} state_e;
  state_e      state_q, state_d;
  logic [17:0] irqs_s, mip_q, en;
  logic        nm_s, nm_q, nmi_q, nmi_d, go, src_en, ack_nmi;
  logic [5:0]  cause_q, cause_d, win;
`ifdef IBEX_IRQ_SYNC_EN
  localparam int ArmLen = 3;
  logic [17:0] irqs_q1, irqs_q2;
  logic        nm_q1, nm_q2;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) {irqs_q1, irqs_q2, nm_q1, nm_q2} <= '0;
    else {irqs_q1, irqs_q2, nm_q1, nm_q2} <= {irqs_i, irqs_q1, irq_nm_i, nm_q1};
  assign irqs_s = irqs_q2;
  assign nm_s   = nm_q2;
`else
  localparam int ArmLen = 1;
  assign irqs_s = irqs_i;
  assign nm_s   = irq_nm_i;
`endif
  // Edge detection stays disarmed until the NMI sample path has refilled after reset,
  // so a line already high at release is not seen as an edge.
  logic [ArmLen-1:0] arm_q;
  always_comb begin
    en      = mstatus_mie_i ? mip_q & mie_i : '0;
    go      = ~debug_mode_i & (nmi_q | (|en));
    ack_nmi = (state_q == REQ) & irq_ack_i & (cause_q == CauseNmi);
    nmi_d   = NmiEnable & ((nm_s & ~nm_q & arm_q[ArmLen-1]) | (nmi_q & ~ack_nmi));
    src_en  = cause_q[4] ? en[cause_q[3:0]] :
              (cause_q == CauseExt) ? en[15] :
              (cause_q == CauseSw)  ? en[17] : en[16];
    win = 6'h00;
    if (en[16]) win = CauseTmr;
    if (en[17]) win = CauseSw;
    if (en[15]) win = CauseExt;
    for (int i = 14; i >= 0; i--) if (en[i]) win = 6'h30 + 6'(i);
    if (nmi_q) win = CauseNmi;
    cause_d = (state_q == IDLE && go) ? win : cause_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      mip_q   <= '0;
      nm_q    <= 1'b0;
      nmi_q   <= 1'b0;
      cause_q <= '0;
      arm_q   <= '0;
    end else begin
      mip_q   <= irqs_s;
      nm_q    <= nm_s;
      nmi_q   <= nmi_d;
      cause_q <= cause_d;
      arm_q   <= ArmLen'({arm_q, 1'b1});
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE) ? (go ? REQ : IDLE) :
              (irq_ack_i | ((cause_q != CauseNmi) & ~src_en)) ? IDLE : REQ;
  always_comb begin
    irq_req_o     = state_q == REQ;
    irq_cause_o   = cause_q;
    mip_o         = mip_q;
    irq_pending_o = (|(mip_q & mie_i)) | nmi_q;
  end
endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// tb_ibex_irq_ctrl: cycle-by-cycle vector table for arbitration/withdraw/NMI behaviour,
// plus hand sequences for reset-release NMI, latency and asynchronous reset.
module tb_ibex_irq_ctrl;
  localparam logic [17:0] T = 18'h10000, S = 18'h20000, E = 18'h08000, M = 18'h3FFFF;
  localparam logic [17:0] X = 18'h18008, F0_14 = 18'h04001, F14 = 18'h04000;
`ifdef IBEX_IRQ_SYNC_EN
  localparam int LAT = 4, MIPL = 3;
`else
  localparam int LAT = 2, MIPL = 1;
`endif
  typedef struct {
    logic [17:0] irqs;
    logic        nm;
    logic [17:0] mie;
    logic        mst, dbg, ack;
    logic [17:0] mip;
    logic        pend, req;
    logic [5:0]  cause;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic [17:0] irqs = '0, mie = '0, mip;
  logic        nm = 1'b1, mst = 1'b0, dbg = 1'b0, ack = 1'b0, pend, req;
  logic [5:0]  cause;
  int          tests = 0, fails = 0;
  vec_t        tbl[$];
  ibex_irq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .irqs_i(irqs), .irq_nm_i(nm), .mie_i(mie),
    .mstatus_mie_i(mst), .debug_mode_i(dbg), .irq_ack_i(ack),
    .mip_o(mip), .irq_pending_o(pend), .irq_req_o(req), .irq_cause_o(cause)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  function automatic vec_t v(logic [17:0] i, logic n, logic [17:0] me, logic ms, logic d, logic a,
                             logic [17:0] mp, logic p, logic r, logic [5:0] c);
    vec_t t;
    t.irqs = i; t.nm = n; t.mie = me; t.mst = ms; t.dbg = d; t.ack = a;
    t.mip = mp; t.pend = p; t.req = r; t.cause = c;
    return t;
  endfunction
  initial begin
    #1;
    chk("rst_mip", 0, 32'(mip), 0);
    chk("rst_pend", 0, 32'(pend), 0);
    chk("rst_req", 0, 32'(req), 0);
    chk("rst_cause", 0, 32'(cause), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("nm_at_release_req", 0, 32'(req), 0);
    chk("nm_at_release_pend", 0, 32'(pend), 0);
    nm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifndef IBEX_IRQ_SYNC_EN
    tbl.push_back(v(T, 0, T, 1, 0, 0, T, 1, 0, 0));
    tbl.push_back(v(T, 0, T, 1, 0, 0, T, 1, 1, 6'h27));
    tbl.push_back(v(T, 0, T, 1, 0, 1, T, 1, 0, 0));
    tbl.push_back(v(0, 0, T, 1, 0, 0, 0, 0, 1, 6'h27));
    tbl.push_back(v(0, 0, T, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(X, 0, M, 1, 0, 0, X, 1, 0, 0));
    tbl.push_back(v(X, 0, M, 1, 0, 0, X, 1, 1, 6'h33));
    tbl.push_back(v(X, 0, M, 1, 0, 1, X, 1, 0, 0));
    tbl.push_back(v(X, 0, M, 1, 0, 0, X, 1, 1, 6'h33));
    tbl.push_back(v(T | E, 0, M, 1, 0, 1, T | E, 1, 0, 0));
    tbl.push_back(v(T | E, 0, M, 1, 0, 0, T | E, 1, 1, 6'h2B));
    tbl.push_back(v(S | T, 0, M, 1, 0, 1, S | T, 1, 0, 0));
    tbl.push_back(v(S | T, 0, M, 1, 0, 0, S | T, 1, 1, 6'h23));
    tbl.push_back(v(0, 0, M, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, M, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(F0_14, 0, M, 1, 0, 0, F0_14, 1, 0, 0));
    tbl.push_back(v(F0_14, 0, M, 1, 0, 0, F0_14, 1, 1, 6'h30));
    tbl.push_back(v(F14, 0, M, 1, 0, 1, F14, 1, 0, 0));
    tbl.push_back(v(F14, 0, M, 1, 0, 0, F14, 1, 1, 6'h3E));
    tbl.push_back(v(0, 0, M, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, M, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(T, 0, T, 1, 0, 0, T, 1, 0, 0));
    tbl.push_back(v(T, 0, T, 1, 0, 0, T, 1, 1, 6'h27));
    tbl.push_back(v(T, 0, T, 0, 0, 0, T, 1, 0, 0));
    tbl.push_back(v(T, 0, T, 0, 0, 0, T, 1, 0, 0));
    tbl.push_back(v(T, 0, T, 1, 0, 0, T, 1, 1, 6'h27));
    tbl.push_back(v(T, 0, T, 1, 0, 1, T, 1, 0, 0));
    tbl.push_back(v(E, 0, E, 1, 1, 0, E, 1, 0, 0));
    tbl.push_back(v(E, 0, E, 1, 1, 0, E, 1, 0, 0));
    tbl.push_back(v(E, 0, E, 1, 1, 0, E, 1, 0, 0));
    tbl.push_back(v(E, 0, E, 1, 0, 0, E, 1, 1, 6'h2B));
    tbl.push_back(v(E, 0, E, 1, 1, 0, E, 1, 1, 6'h2B));
    tbl.push_back(v(E, 0, E, 1, 0, 1, E, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 1, 6'h3F));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 1, 6'h3F));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 1, 6'h3F));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(T, 0, T, 1, 0, 1, T, 1, 0, 0));
    tbl.push_back(v(T, 0, T, 1, 0, 1, T, 1, 1, 6'h27));
    tbl.push_back(v(T, 0, T, 1, 0, 1, T, 1, 0, 0));
    tbl.push_back(v(0, 0, T, 1, 0, 0, 0, 0, 1, 6'h27));
    tbl.push_back(v(0, 0, T, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(T, 0, T, 1, 0, 0, T, 1, 0, 0));
    tbl.push_back(v(T, 0, T, 1, 0, 0, T, 1, 1, 6'h27));
    tbl.push_back(v(T, 1, T, 1, 0, 0, T, 1, 1, 6'h27));
    tbl.push_back(v(T, 0, T, 1, 0, 1, T, 1, 0, 0));
    tbl.push_back(v(T, 0, T, 1, 0, 0, T, 1, 1, 6'h3F));
    tbl.push_back(v(T, 0, T, 1, 0, 1, T, 1, 0, 0));
    tbl.push_back(v(0, 0, T, 1, 0, 0, 0, 0, 1, 6'h27));
    tbl.push_back(v(0, 0, T, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < tbl.size(); k++) begin
      irqs = tbl[k].irqs; nm = tbl[k].nm; mie = tbl[k].mie;
      mst = tbl[k].mst; dbg = tbl[k].dbg; ack = tbl[k].ack;
      @(posedge clk);
      #1;
      chk("mip", k, 32'(mip), 32'(tbl[k].mip));
      chk("pend", k, 32'(pend), 32'(tbl[k].pend));
      chk("req", k, 32'(req), 32'(tbl[k].req));
      if (tbl[k].req) chk("cause", k, 32'(cause), 32'(tbl[k].cause));
    end
`endif
    begin
      int mipc, reqc;
      mipc = 0;
      reqc = 0;
      irqs = T; mie = T; mst = 1'b1; dbg = 1'b0; ack = 1'b0; nm = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk);
        #1;
        if (mip == T && mipc == 0) mipc = c;
        if (req && reqc == 0) reqc = c;
      end
      chk("mip_latency", 0, 32'(mipc), 32'(MIPL));
      chk("req_latency", 0, 32'(reqc), 32'(LAT));
      chk("lat_cause", 0, 32'(cause), 32'h27);
    end
    nm = 1'b1;
    mie = '0;
    @(posedge clk);
    #1 nm = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("nmi_req", 0, 32'(req), 1);
    chk("nmi_cause", 0, 32'(cause), 32'h3F);
    chk("nmi_pend", 0, 32'(pend), 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_req", 0, 32'(req), 0);
    chk("async_rst_pend", 0, 32'(pend), 0);
    chk("async_rst_mip", 0, 32'(mip), 0);
    chk("async_rst_cause", 0, 32'(cause), 0);
    irqs = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("nmi_lost_req", 0, 32'(req), 0);
    chk("nmi_lost_pend", 0, 32'(pend), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ibex_irq_ctrl.md
IBEX_IRQ_CTRL -- requirements
Module: ibex_irq_ctrl

Interface
REQ-001 Parameter: NmiEnable, 1'b1, when 0 irq_nm_i is ignored and NMI logic is removed.
REQ-002 clk_i  input  1  core clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 irqs_i  input  18 (ibex_pkg::irqs_t)  raw level interrupt lines: software, timer, external, fast[14:0].
REQ-005 irq_nm_i  input  1  raw non-maskable interrupt line, rising-edge sensitive.
REQ-006 mie_i  input  18 (irqs_t)  per-source enable, from the CSR block.
REQ-007 mstatus_mie_i  input  1  global machine interrupt enable.
REQ-008 debug_mode_i  input  1  core in debug mode; blocks new requests.
REQ-009 irq_ack_i  input  1  controller accepts the presented request; single-cycle pulse.
REQ-010 mip_o  output  18 (irqs_t)  registered pending bits, for the CSR block's mip read.
REQ-011 irq_pending_o  output  1  any (mip_o & mie_i) bit set, or NMI latched; wake-from-WFI indication.
REQ-012 irq_req_o  output  1  request presented to the controller.
REQ-013 irq_cause_o  output  6 (exc_cause_e)  cause of the presented request; valid while irq_req_o=1.

Function
REQ-014 Each cycle, irqs_i is sampled into mip_q; mip_o = mip_q; 1-cycle latency from input to mip_o.
REQ-015 NMI: a rising edge of the sampled irq_nm_i sets nmi_q; nmi_q stays set until acknowledged as NMI; further edges while set are absorbed.
REQ-016 Enabled set: en = mip_q & mie_i when mstatus_mie_i=1, else 0; NMI is always eligible.
REQ-017 Priority, highest first: NMI (cause {1,31}), fast[0]..fast[14] (cause {1,16+i}), external {1,11}, software {1,3}, timer {1,7}.
REQ-018 FSM has two states, IDLE and REQ; irq_req_o = (state==REQ).
REQ-019 IDLE->REQ when debug_mode_i=0 and (nmi_q or en!=0); the winning cause is latched into cause_q on the same edge.
REQ-020 In REQ, cause_q holds; no re-arbitration, even if a higher-priority source arrives.
REQ-021 REQ->IDLE on irq_ack_i=1; if cause_q is NMI, nmi_q clears on the same edge.
REQ-022 In REQ, if the latched maskable source becomes ineligible (its mip bit, mie bit or mstatus_mie_i drops) and irq_ack_i=0, the request is withdrawn: REQ->IDLE next edge.
REQ-023 An NMI request is never withdrawn.
REQ-024 irq_ack_i in IDLE is ignored and changes no state.
REQ-025 Simultaneous ack and withdraw condition: ack wins, and the transition is REQ->IDLE.
REQ-026 From request-eligible input change to irq_req_o=1: 2 cycles (sample, then FSM), with no synchronizer.
REQ-027 After ack, IDLE lasts at least one cycle before the next request.
REQ-028 debug_mode_i=1 in REQ does not withdraw the request; it only blocks IDLE->REQ.
REQ-029 irq_pending_o is combinational from mip_q, mie_i and nmi_q, independent of mstatus_mie_i and debug_mode_i.

Reset
REQ-030 rst_i asynchronously forces: mip_q=0, nmi_q=0, the irq_nm_i sample register=0, cause_q=0, state=IDLE.
REQ-031 Resulting output values: mip_o=0, irq_pending_o=0, irq_req_o=0, irq_cause_o=0.
REQ-032 Reset asserted in REQ drops irq_req_o immediately; any pending NMI is lost.
REQ-033 irq_nm_i held high at reset release does not create an NMI (no edge).

Configuration
REQ-034 Macro IBEX_IRQ_SYNC_EN: when defined, irqs_i and irq_nm_i each pass through a 2-flop synchronizer, reset to 0, before mip_q and the NMI edge detector.
REQ-035 With IBEX_IRQ_SYNC_EN defined, the REQ-026 latency becomes 4 cycles and mip_o latency becomes 3 cycles.
REQ-036 Without IBEX_IRQ_SYNC_EN, inputs are assumed synchronous to clk_i and the latencies of REQ-014 and REQ-026 apply.

Verification
REQ-037 Set mie_i.irq_timer=1, mstatus_mie_i=1, raise timer at cycle 0 -> irq_req_o=1 at cycle 2 with cause 6'h27; ack -> irq_req_o=0 next cycle.
REQ-038 Raise timer, fast[3] and external together -> cause 6'h33 (fast 3); after ack with all still high -> cause 6'h33 again after one IDLE cycle.
REQ-039 Drive an irq_nm_i pulse while mstatus_mie_i=0 -> request with cause 6'h3F; hold without ack and drop mstatus_mie_i -> request stays asserted.
REQ-040 Timer request in REQ; clear mstatus_mie_i with no ack -> irq_req_o=0 next cycle; irq_pending_o stays 1.
REQ-041 debug_mode_i=1 with external pending and enabled -> irq_req_o stays 0; deassert debug_mode_i -> request 1 cycle later.
REQ-042 Assert rst_i mid-REQ -> outputs go to 0 without a clock edge; repeat the REQ-037 stimulus with IBEX_IRQ_SYNC_EN defined -> request at cycle 4.
